// File: rtl/tm1638_sequencer.sv
// tm1638_sequencer: drives a generic SPI controller to refresh one or more
// TM1638 display/key-scan chips in a fixed command frame.
//
// Optional feature: define TM1638_KEY_SCAN_EN to enable the key-scan read
// (0x42) per chip; when undefined keys and keys_changed are constant 0.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   display_mem      16-byte raw image per chip (chip c byte b at c*128+b*8)
//   brightness       PWM level 0..7, sampled when the brightness cmd is built
//   display_on       display enable, sampled with brightness
//   busy             SPI controller busy
//   in_data          four key-scan bytes returned by the controller
//   activate         request to start an SPI transaction
//   in_cs            one-hot chip select for the transaction
//   out_data         bytes to send, byte 0 first
//   out_count        number of bytes to send
//   in_count         number of bytes to read (0 or 4)
//   keys             decoded keys, 8 per chip, 1 = pressed
//   keys_changed     one-clock pulse when any key bit changes
//   frame_done       one-clock pulse at the end of every full frame
module tm1638_sequencer #(
   parameter int NUM_CHIPS       = 1,
   parameter int BURST_BYTES     = 4,
   parameter int POWER_UP_CYCLES = 2_000_000,
   parameter int REFRESH_CYCLES  = 230_000
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_CHIPS*128-1:0]         display_mem,
   input  logic [2:0]                       brightness,
   input  logic                             display_on,
   input  logic                             busy,
   input  logic [31:0]                      in_data,
   output logic                             activate,
   output logic [NUM_CHIPS-1:0]             in_cs,
   output logic [(BURST_BYTES+1)*8-1:0]     out_data,
   output logic [$clog2(BURST_BYTES+2)-1:0] out_count,
   output logic [2:0]                       in_count,
   output logic [NUM_CHIPS*8-1:0]           keys,
   output logic                             keys_changed,
   output logic                             frame_done
);

   localparam int NB  = 16 / BURST_BYTES;
   localparam int DW  = (BURST_BYTES + 1) * 8;
   localparam int OCW = $clog2(BURST_BYTES + 2);
   localparam int CW  = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
   localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW  = (POWER_UP_CYCLES > 1) ?
                        $clog2(POWER_UP_CYCLES + 1) : 1;
   localparam int RW  = (REFRESH_CYCLES > 1) ?
                        $clog2(REFRESH_CYCLES + 1) : 1;

   localparam logic [NUM_CHIPS-1:0] CS_ONE = 1;

   localparam logic [3:0] POWER_UP  = 4'd0;
   localparam logic [3:0] AUTO_INC  = 4'd1;
   localparam logic [3:0] XMIT      = 4'd2;
   localparam logic [3:0] BRIGHT    = 4'd3;
   localparam logic [3:0] READ_KEYS = 4'd4;
   localparam logic [3:0] NEXT_CHIP = 4'd5;
   localparam logic [3:0] DELAY     = 4'd6;
   localparam logic [3:0] SEND      = 4'd7;
   localparam logic [3:0] AWAIT     = 4'd8;

   logic [3:0]     state;
   logic [3:0]     ret_state;
   logic [PW-1:0]  pwr_cnt;
   logic [RW-1:0]  dly_cnt;
   logic [CW-1:0]  chip;
   logic [BW-1:0]  burst;
   logic           seen_busy;
   logic [DW-1:0]  q_data;
   logic [OCW-1:0] q_count;
   logic [2:0]     q_in;
   logic [NUM_CHIPS*8-1:0] keys_q;

   logic [127:0]   chip_img;
   logic [7:0]     addr;
   logic [DW-1:0]  xmit_img;

   logic unused_in;
   assign unused_in = ^in_data;

   // Burst image for the current chip/burst, latched into the send queue
   // only on the XMIT clock so later display_mem edits don't leak in.
   always_comb begin
      chip_img = display_mem[chip*128 +: 128];
      addr     = 8'(burst) * 8'(BURST_BYTES);
      xmit_img = '0;
      xmit_img[7:0] = 8'hC0 + addr;
      for (int j = 0; j < BURST_BYTES; j++) begin
         xmit_img[(j+1)*8 +: 8] = chip_img[(addr + j)*8 +: 8];
      end
   end

`ifdef TM1638_KEY_SCAN_EN
   // K-line bits 0 and 4 of each scan byte carry the two key columns.
   logic [7:0] scan;
   always_comb begin
      scan = '0;
      for (int i = 0; i < 4; i++) begin
         scan[i]   = in_data[i*8];
         scan[4+i] = in_data[i*8+4];
      end
   end
`endif

   assign keys = keys_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= POWER_UP;
         ret_state    <= POWER_UP;
         pwr_cnt      <= PW'(POWER_UP_CYCLES);
         dly_cnt      <= '0;
         chip         <= '0;
         burst        <= '0;
         seen_busy    <= 1'b0;
         q_data       <= '0;
         q_count      <= '0;
         q_in         <= '0;
         activate     <= 1'b0;
         in_cs        <= '0;
         out_data     <= '0;
         out_count    <= '0;
         in_count     <= '0;
         keys_q       <= '0;
         keys_changed <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         keys_changed <= 1'b0;
         frame_done   <= 1'b0;
         unique case (state)
            POWER_UP: begin
               if (pwr_cnt > PW'(1)) begin
                  pwr_cnt <= pwr_cnt - PW'(1);
               end else begin
                  chip  <= '0;
                  burst <= '0;
                  state <= AUTO_INC;
               end
            end
            AUTO_INC: begin
               q_data    <= DW'(8'h40);
               q_count   <= OCW'(1);
               q_in      <= 3'd0;
               ret_state <= XMIT;
               state     <= SEND;
            end
            XMIT: begin
               q_data  <= xmit_img;
               q_count <= OCW'(BURST_BYTES + 1);
               q_in    <= 3'd0;
               if (burst == BW'(NB - 1)) begin
                  burst     <= '0;
                  ret_state <= BRIGHT;
               end else begin
                  burst     <= burst + BW'(1);
                  ret_state <= XMIT;
               end
               state <= SEND;
            end
            BRIGHT: begin
               q_data  <= DW'({4'h8, display_on, brightness});
               q_count <= OCW'(1);
               q_in    <= 3'd0;
`ifdef TM1638_KEY_SCAN_EN
               ret_state <= READ_KEYS;
`else
               ret_state <= NEXT_CHIP;
`endif
               state <= SEND;
            end
            READ_KEYS: begin
               q_data    <= DW'(8'h42);
               q_count   <= OCW'(1);
               q_in      <= 3'd4;
               ret_state <= NEXT_CHIP;
               state     <= SEND;
            end
            NEXT_CHIP: begin
               if (chip != CW'(NUM_CHIPS - 1)) begin
                  chip  <= chip + CW'(1);
                  state <= AUTO_INC;
               end else begin
                  frame_done <= 1'b1;
                  chip       <= '0;
                  dly_cnt    <= RW'(REFRESH_CYCLES);
                  state      <= DELAY;
               end
            end
            DELAY: begin
               if (dly_cnt > RW'(1)) begin
                  dly_cnt <= dly_cnt - RW'(1);
               end else begin
                  state <= AUTO_INC;
               end
            end
            SEND: begin
               if (!busy) begin
                  out_data  <= q_data;
                  out_count <= q_count;
                  in_count  <= q_in;
                  in_cs     <= CS_ONE << chip;
                  activate  <= 1'b1;
                  seen_busy <= 1'b0;
                  state     <= AWAIT;
               end
            end
            AWAIT: begin
               // Hold the request until the controller acknowledges with
               // busy, then return on the first idle after that.
               if (!seen_busy) begin
                  if (busy) begin
                     seen_busy <= 1'b1;
                     activate  <= 1'b0;
                  end
               end else if (!busy) begin
                  seen_busy <= 1'b0;
                  state     <= ret_state;
`ifdef TM1638_KEY_SCAN_EN
                  if (in_count == 3'd4) begin
                     keys_q[chip*8 +: 8] <= scan;
                     keys_changed <= (keys_q[chip*8 +: 8] != scan);
                  end
`endif
               end
            end
            default: state <= POWER_UP;
         endcase
      end
   end

endmodule
